nx_stream_arbiter: RTL and testbench

- Round-robin arbiter that shares one outbound message stream between STREAMS inbound valid/ready streams.
- Multi-beat messages, delimited by a per-stream last flag, are never interleaved. The granted stream holds the output until its last beat is accepted.
- Output is a registered single-entry stage: one-cycle latency, full throughput.
- Sits in front of the node egress skid buffer, merging core, mesh-forward and control message sources.

---
 rtl/nx_stream_arbiter.sv | 117 +++++++++++
 tb/tb_nx_stream_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nx_stream_arbiter.sv
// Round-robin message arbiter: merges STREAMS valid/ready inputs into one
// registered output stream without interleaving multi-beat messages.
module nx_stream_arbiter #(
  parameter int STREAMS      = 4,
  parameter int STREAM_WIDTH = 32,
  localparam int IDX_W       = $clog2(STREAMS)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [STREAMS*STREAM_WIDTH-1:0] inbound_data_i,
  input  logic [STREAMS-1:0]              inbound_last_i,
  input  logic [STREAMS-1:0]              inbound_valid_i,
  output logic [STREAMS-1:0]              inbound_ready_o,
  output logic [STREAM_WIDTH-1:0]         outbound_data_o,
  output logic                            outbound_last_o,
  output logic [IDX_W-1:0]                outbound_source_o,
  output logic                            outbound_valid_o,
  input  logic                            outbound_ready_i,
  output logic                            locked_o
);

  logic [STREAM_WIDTH-1:0] data_q, data_d;
  logic                    last_q, last_d;
  logic [IDX_W-1:0]        src_q, src_d;
  logic                    valid_q, valid_d;
  logic                    locked_q, locked_d;
  logic [IDX_W-1:0]        lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0]        grant_q, grant_d;

  logic             slot_free;
  logic             cand;
  logic             accept;
  logic [IDX_W-1:0] sel;
  int               n;

  assign slot_free = !valid_q || outbound_ready_i;
  assign accept    = slot_free && cand;

  // Pick the locked stream, else the first valid stream after the last grant.
  always_comb begin
    sel  = '0;
    cand = 1'b0;
    n    = 0;
    if (locked_q) begin
      sel  = lock_idx_q;
      cand = inbound_valid_i[lock_idx_q];
    end else begin
      for (int k = 1; k <= STREAMS; k++) begin
        n = (int'(grant_q) + k) % STREAMS;
        if (!cand && inbound_valid_i[IDX_W'(n)]) begin
          cand = 1'b1;
          sel  = IDX_W'(n);
        end
      end
    end
  end

  // Ready goes only to the selected stream, and only when the slot can load.
  always_comb begin
    inbound_ready_o = '0;
    if (accept) inbound_ready_o[sel] = 1'b1;
  end

  // Next state of the output register, lock and round-robin pointer.
  always_comb begin
    data_d     = data_q;
    last_d     = last_q;
    src_d      = src_q;
    valid_d    = valid_q;
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    grant_d    = grant_q;
    if (accept) begin
      data_d  = inbound_data_i[int'(sel)*STREAM_WIDTH +: STREAM_WIDTH];
      last_d  = inbound_last_i[sel];
      src_d   = sel;
      valid_d = 1'b1;
      if (inbound_last_i[sel]) begin
        locked_d = 1'b0;
        grant_d  = sel;
      end else begin
        locked_d   = 1'b1;
        lock_idx_d = sel;
      end
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
  end

  // State registers; stream 0 has priority after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q     <= '0;
      last_q     <= 1'b0;
      src_q      <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
      grant_q    <= IDX_W'(STREAMS - 1);
    end else begin
      data_q     <= data_d;
      last_q     <= last_d;
      src_q      <= src_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
      grant_q    <= grant_d;
    end
  end

  assign outbound_data_o   = data_q;
  assign outbound_last_o   = last_q;
  assign outbound_source_o = src_q;
  assign outbound_valid_o  = valid_q;
  assign locked_o          = locked_q;

endmodule

// File: tb/tb_nx_stream_arbiter.sv
// Scoreboard bench for nx_stream_arbiter: message-level round-robin model,
// directed scenarios followed by randomized traffic.
module tb_nx_stream_arbiter;
  localparam int S  = 4;
  localparam int W  = 32;
  localparam int IW = $clog2(S);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [S*W-1:0] in_data = '0;
  logic [S-1:0]   in_last = '0;
  logic [S-1:0]   in_valid = '0;
  logic [S-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [IW-1:0]  out_src;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           locked;

  nx_stream_arbiter #(.STREAMS(S), .STREAM_WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst),
    .inbound_data_i(in_data), .inbound_last_i(in_last),
    .inbound_valid_i(in_valid), .inbound_ready_o(in_ready),
    .outbound_data_o(out_data), .outbound_last_o(out_last),
    .outbound_source_o(out_src), .outbound_valid_o(out_valid),
    .outbound_ready_i(out_ready), .locked_o(locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // per-stream pending beats {last, data}; expected outputs {src, last, data}
  logic [W:0]      sq[S][$];
  logic [IW+W:0]   expq[$];

  // reference model state: message-level round robin
  int mlg   = S - 1;
  bit mlock = 0;
  int mlidx = 0;
  bit mval  = 0;

  // stimulus controls
  logic [S-1:0] gate  = '1;
  bit           vrand = 0;
  bit           rrand = 0;
  bit           rfix  = 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int pick(input logic [S-1:0] v);
    if (mlock) return v[mlidx] ? mlidx : -1;
    for (int k = 1; k <= S; k++) begin
      if (v[(mlg + k) % S]) return (mlg + k) % S;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < S; i++) begin
      bit v;
      v = (sq[i].size() > 0) && gate[i] && (!vrand || $urandom_range(0, 3) != 0);
      in_valid[i] = v;
      if (sq[i].size() > 0) begin
        in_data[i*W +: W] = sq[i][0][W-1:0];
        in_last[i] = sq[i][0][W];
      end else begin
        in_data[i*W +: W] = $urandom;
        in_last[i] = $urandom_range(0, 1);
      end
    end
    out_ready = rrand ? ($urandom_range(0, 2) != 0) : rfix;
  endtask

  // Evaluate the model against the inputs driven this cycle (before the edge).
  task automatic model_eval();
    bit sf;
    int s;
    logic [S-1:0] er;
    logic [W:0] b;
    sf = !mval || out_ready;
    s  = pick(in_valid);
    er = '0;
    if (sf && s >= 0) er[s] = 1'b1;
    chk("inbound_ready", 64'(in_ready), 64'(er));
    chk("locked", 64'(locked), 64'(mlock));
    chk("out_valid", 64'(out_valid), 64'(mval));
    if (sf && s >= 0) begin
      b = sq[s].pop_front();
      expq.push_back({IW'(s), b[W], b[W-1:0]});
      mval = 1;
      if (b[W]) begin
        mlock = 0;
        mlg = s;
      end else begin
        mlock = 1;
        mlidx = s;
      end
    end else if (sf) begin
      mval = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    model_eval();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < S; i++) sq[i].delete();
    expq.delete();
    mlg = S - 1;
    mlock = 0;
    mlidx = 0;
    mval = 0;
    drive();
    #1;
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_src", 64'(out_src), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push_msg(input int s, input int len, input logic [W-1:0] base);
    for (int i = 0; i < len; i++)
      sq[s].push_back({(i == len - 1), base + W'(i)});
  endtask

  // Monitor: compare each beat as it is consumed; check hold while stalled.
  bit           pv = 0;
  logic [W-1:0] pd;
  logic         pl;
  logic [IW-1:0] ps;
  always @(negedge clk) begin
    logic [IW+W:0] e;
    if (rst) begin
      pv = 0;
    end else begin
      if (pv) begin
        chk("stall_data", 64'(out_data), 64'(pd));
        chk("stall_last", 64'(out_last), 64'(pl));
        chk("stall_src", 64'(out_src), 64'(ps));
        chk("stall_valid", 64'(out_valid), 64'd1);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_beat", 64'(out_data), 64'hDEAD);
        end else begin
          e = expq.pop_front();
          chk("out_data", 64'(out_data), 64'(e[W-1:0]));
          chk("out_last", 64'(out_last), 64'(e[W]));
          chk("out_src", 64'(out_src), 64'(e[IW+W:W+1]));
        end
      end
      pv = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
      ps = out_src;
    end
  end

  initial begin
    int busy;
    @(negedge clk);
    chk("por_data", 64'(out_data), 64'd0);
    chk("por_valid", 64'(out_valid), 64'd0);
    chk("por_locked", 64'(locked), 64'd0);
    chk("por_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // streams 0 and 2 single beats
    push_msg(0, 1, 32'hA0);
    push_msg(2, 1, 32'hA2);
    repeat (4) step();

    // all streams continuously valid, single beats
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < S; i++) push_msg(i, 1, 32'h100 + W'(16 * r + i));
    repeat (10) step();

    // stream 1 three-beat message while stream 0 waits
    do_reset();
    push_msg(1, 3, 32'h10);
    push_msg(0, 1, 32'h50);
    gate = 4'b0010;
    step();
    gate = '1;
    repeat (6) step();

    // downstream stall for 5 cycles
    do_reset();
    for (int i = 0; i < 4; i++) push_msg(1, 1, 32'h200 + W'(i));
    repeat (2) step();
    rfix = 0;
    repeat (5) step();
    rfix = 1;
    repeat (5) step();

    // locked stream 3 drops valid mid-message
    push_msg(3, 3, 32'h30);
    gate = 4'b1000;
    step();
    push_msg(0, 2, 32'h60);
    gate = 4'b0001;
    repeat (4) step();
    gate = '1;
    repeat (8) step();

    // reset mid-message from stream 2
    do_reset();
    push_msg(2, 3, 32'h70);
    repeat (2) step();
    do_reset();
    push_msg(2, 1, 32'hB2);
    push_msg(0, 1, 32'hB0);
    repeat (4) step();

    // randomized traffic
    vrand = 1;
    rrand = 1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0)
        push_msg($urandom_range(0, S - 1), $urandom_range(1, 4), $urandom);
      step();
    end
    vrand = 0;
    rrand = 0;
    rfix  = 1;
    busy  = 0;
    for (int c = 0; c < 500; c++) begin
      busy = expq.size();
      for (int i = 0; i < S; i++) busy += sq[i].size();
      if (busy == 0 && !out_valid) break;
      step();
    end
    chk("drain_pending", 64'(busy), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
